// File: rtl/i2c_resp_pkg.sv
// Purpose: shared types and constants for the I2C target responder.
//   resp_state_t        : protocol FSM states of the responder
//   i2c_op_t            : R/W bit of the address byte (0 = write, 1 = read)
//   DEFAULT_TARGET_ADDR : 7-bit address the responder answers to by default
package i2c_resp_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WR_BYTE   = 4'd5,
    WR_ACK    = 4'd6,
    RD_BYTE   = 4'd7,
    RD_ACK    = 4'd8,
    WAIT_STOP = 4'd9
  } resp_state_t;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } i2c_op_t;

  localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h22;

endpackage

// File: rtl/i2c_bus_sync.sv
// Purpose: brings the asynchronous scl/sda pins into the clk_i domain and
//   derives single-cycle bus events. Each pin goes through two synchronizer
//   flops plus one history flop; the event pulses are registered, so an event
//   is visible three clk_i edges after the pin change.
// Ports:
//   clk_i, rst_i : system clock, synchronous active-high reset
//   scl_i, sda_i : raw I2C pins
//   scl_rise     : pulse, scl went 0 -> 1
//   scl_fall     : pulse, scl went 1 -> 0
//   start_det    : pulse, sda fell while scl stayed high
//   stop_det     : pulse, sda rose while scl stayed high
//   sda_bit      : synchronized sda, aligned with the event pulses
module i2c_bus_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_bit
);

  logic scl_meta, scl_sync, scl_hist;
  logic sda_meta, sda_sync, sda_hist;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // Idle bus is high; resetting to 1 avoids phantom edges after reset.
      scl_meta  <= 1'b1;
      scl_sync  <= 1'b1;
      scl_hist  <= 1'b1;
      sda_meta  <= 1'b1;
      sda_sync  <= 1'b1;
      sda_hist  <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_bit   <= 1'b1;
    end else begin
      scl_meta  <= scl_i;
      scl_sync  <= scl_meta;
      scl_hist  <= scl_sync;
      sda_meta  <= sda_i;
      sda_sync  <= sda_meta;
      sda_hist  <= sda_sync;
      scl_rise  <= scl_sync & ~scl_hist;
      scl_fall  <= ~scl_sync & scl_hist;
      // scl must be high in both samples so an sda edge racing an scl edge
      // is never mistaken for START/STOP.
      start_det <= scl_sync & scl_hist & ~sda_sync & sda_hist;
      stop_det  <= scl_sync & scl_hist & sda_sync & ~sda_hist;
      sda_bit   <= sda_sync;
    end
  end

endmodule

// File: rtl/i2c_target_responder.sv
// Purpose: synthesizable I2C target used as a loopback responder for the
//   I2CMB master. Decodes START/STOP, matches a 7-bit address, ACKs, stores
//   written bytes in a small register file and returns them on reads.
//   Write transfer: address+W, pointer byte, then data bytes stored at the
//   auto-incrementing pointer. Read transfer: address+R, bytes returned from
//   the pointer until the master NACKs. Pointer survives repeated START.
// Ports:
//   clk_i, rst_i : system clock (>= 8x SCL), synchronous active-high reset
//   scl_i, sda_i : I2C pins (asynchronous, sampled)
//   sda_o        : open-drain drive, 0 = pull low, 1 = release
//   busy_o       : high from an addressed START until STOP / repeated START
//   wr_stb_o     : one-cycle pulse per stored byte
//   wr_ptr_o     : entry written on wr_stb_o
//   wr_data_o    : byte written on wr_stb_o
//   rd_stb_o     : one-cycle pulse when a byte is loaded for transmit
//   dbg_state    : current FSM state (resp_state_t encoding)
module i2c_target_responder
  import i2c_resp_pkg::*;
#(
  parameter int                        I2C_ADDR_WIDTH = 7,
  parameter int                        I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] TARGET_ADDR    = DEFAULT_TARGET_ADDR,
  parameter int                        MEM_DEPTH      = 16,
  localparam int                       PTR_W          = $clog2(MEM_DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      sda_o,
  output logic                      busy_o,
  output logic                      wr_stb_o,
  output logic [PTR_W-1:0]          wr_ptr_o,
  output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
  output logic                      rd_stb_o,
  output logic [3:0]                dbg_state
);

  localparam logic [3:0]       LAST_BIT = 4'(I2C_DATA_WIDTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic scl_rise, scl_fall, start_det, stop_det, sda_bit;

  i2c_bus_sync u_sync (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_bit   (sda_bit)
  );

  resp_state_t               state;
  i2c_op_t                   op;
  logic [3:0]                bit_cnt;
  logic [I2C_DATA_WIDTH-1:0] shreg;
  logic [I2C_DATA_WIDTH-1:0] tx_byte;
  logic [PTR_W-1:0]          ptr;
  logic [I2C_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Byte as it will look once the bit arriving on this scl rise is shifted in.
  logic [I2C_DATA_WIDTH-1:0] rx_next;
  logic [I2C_DATA_WIDTH-1:0] rd_word;
  assign rx_next   = {shreg[I2C_DATA_WIDTH-2:0], sda_bit};
  assign rd_word   = mem[ptr];
  assign dbg_state = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      op        <= WRITE;
      sda_o     <= 1'b1;
      busy_o    <= 1'b0;
      wr_stb_o  <= 1'b0;
      rd_stb_o  <= 1'b0;
      wr_ptr_o  <= '0;
      wr_data_o <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      tx_byte   <= '0;
      ptr       <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_stb_o <= 1'b0;
      rd_stb_o <= 1'b0;
      if (stop_det) begin
        // Any partial byte is simply dropped: nothing is stored before bit 8.
        state   <= IDLE;
        sda_o   <= 1'b1;
        busy_o  <= 1'b0;
        bit_cnt <= '0;
      end else if (start_det) begin
        // Fresh or repeated START: the pointer is kept for write-then-read.
        state   <= ADDR;
        sda_o   <= 1'b1;
        busy_o  <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE, WAIT_STOP: ;

          ADDR: begin
            if (scl_rise) begin
              shreg   <= rx_next;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              op      <= i2c_op_t'(shreg[0]);
              if (shreg[I2C_DATA_WIDTH-1 -: I2C_ADDR_WIDTH] == TARGET_ADDR) begin
                sda_o  <= 1'b0;
                busy_o <= 1'b1;
                state  <= ADDR_ACK;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              if (op == READ) begin
                // First read byte goes out on the same fall that ends the ACK.
                sda_o    <= rd_word[I2C_DATA_WIDTH-1];
                tx_byte  <= {rd_word[I2C_DATA_WIDTH-2:0], 1'b0};
                rd_stb_o <= 1'b1;
                ptr      <= ptr + PTR_ONE;
                state    <= RD_BYTE;
              end else begin
                sda_o <= 1'b1;
                state <= PTR;
              end
            end
          end

          PTR: begin
            if (scl_rise) begin
              shreg   <= rx_next;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              ptr     <= shreg[PTR_W-1:0];
              sda_o   <= 1'b0;
              state   <= PTR_ACK;
            end
          end

          PTR_ACK: begin
            if (scl_fall) begin
              sda_o <= 1'b1;
              state <= WR_BYTE;
            end
          end

          WR_BYTE: begin
            if (scl_rise) begin
              shreg   <= rx_next;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == LAST_BIT - 4'd1) begin
                mem[ptr]  <= rx_next;
                wr_stb_o  <= 1'b1;
                wr_ptr_o  <= ptr;
                wr_data_o <= rx_next;
                ptr       <= ptr + PTR_ONE;
              end
            end else if (scl_fall && bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              sda_o   <= 1'b0;
              state   <= WR_ACK;
            end
          end

          WR_ACK: begin
            if (scl_fall) begin
              sda_o <= 1'b1;
              state <= WR_BYTE;
            end
          end

          RD_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == LAST_BIT) begin
                // Hand sda to the master for its ACK/NACK bit.
                bit_cnt <= '0;
                sda_o   <= 1'b1;
                state   <= RD_ACK;
              end else begin
                sda_o   <= tx_byte[I2C_DATA_WIDTH-1];
                tx_byte <= {tx_byte[I2C_DATA_WIDTH-2:0], 1'b0};
              end
            end
          end

          RD_ACK: begin
            // A NACK leaves before the fall, so a fall here always means ACK.
            if (scl_rise) begin
              if (sda_bit) state <= WAIT_STOP;
            end else if (scl_fall) begin
              sda_o    <= rd_word[I2C_DATA_WIDTH-1];
              tx_byte  <= {rd_word[I2C_DATA_WIDTH-2:0], 1'b0};
              rd_stb_o <= 1'b1;
              ptr      <= ptr + PTR_ONE;
              state    <= RD_BYTE;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed bench for i2c_target_responder: a bit-banged I2C master drives a
// wired-AND bus; write strobes are checked against an expected queue, read
// bytes and status outputs against hand-computed values.
module tb_i2c_target_responder;
  import i2c_resp_pkg::*;

  localparam int Q = 6;  // clk_i cycles per quarter SCL period

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_o, busy_o, wr_stb_o, rd_stb_o;
  logic [3:0] wr_ptr_o;
  logic [7:0] wr_data_o;
  logic [3:0] dbg_state;
  wire        sda_bus = m_sda & sda_o;

  i2c_target_responder dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .scl_i     (m_scl),
    .sda_i     (sda_bus),
    .sda_o     (sda_o),
    .busy_o    (busy_o),
    .wr_stb_o  (wr_stb_o),
    .wr_ptr_o  (wr_ptr_o),
    .wr_data_o (wr_data_o),
    .rd_stb_o  (rd_stb_o),
    .dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic [11:0] exp_q[$];  // {ptr, data} of each expected write strobe

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && rd_stb_o) rd_cnt++;
    if (!rst && wr_stb_o) begin
      wr_cnt++;
      check("wr_stb_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("wr_strobe", 32'({wr_ptr_o, wr_data_o}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Works both from idle and as a repeated START with scl low.
  task automatic i2c_start();
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b1; wait_clk(Q);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;    wait_clk(Q);
    m_scl = 1'b1; wait_clk(2 * Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    b = sda_bus;  wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  // ---------------- directed sequence ----------------
  logic       ack;
  logic [7:0] rd;
  logic [7:0] addr_w;

  initial begin
    addr_w = 8'h44;
    wait_clk(4);
    check("rst_sda_o", 32'(sda_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_wr_stb", 32'(wr_stb_o), 32'd0);
    check("rst_rd_stb", 32'(rd_stb_o), 32'd0);
    check("rst_wr_ptr", 32'(wr_ptr_o), 32'd0);
    check("rst_wr_data", 32'(wr_data_o), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    wait_clk(4);

    // 1: write 0xA5 to entry 3
    i2c_start();
    write_byte(8'h44, ack); check("t1_addr_ack", 32'(ack), 32'd0);
    check("t1_busy", 32'(busy_o), 32'd1);
    write_byte(8'h03, ack); check("t1_ptr_ack", 32'(ack), 32'd0);
    exp_q.push_back({4'h3, 8'hA5});
    write_byte(8'hA5, ack); check("t1_data_ack", 32'(ack), 32'd0);
    i2c_stop(); wait_clk(Q);
    check("t1_busy_after_stop", 32'(busy_o), 32'd0);
    check("t1_state_idle", 32'(dbg_state), 32'(IDLE));
    check("t1_wr_cnt", 32'(wr_cnt), 32'd1);
    check("t1_wr_ptr", 32'(wr_ptr_o), 32'h3);
    check("t1_wr_data", 32'(wr_data_o), 32'hA5);

    // 2: set pointer 3, repeated START, read one byte with NACK
    i2c_start();
    write_byte(8'h44, ack); check("t2_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h03, ack); check("t2_ptr_ack", 32'(ack), 32'd0);
    i2c_start();
    write_byte(8'h45, ack); check("t2_raddr_ack", 32'(ack), 32'd0);
    read_byte(rd, 1'b1);    check("t2_read", 32'(rd), 32'hA5);
    check("t2_state_wait_stop", 32'(dbg_state), 32'(WAIT_STOP));
    i2c_stop(); wait_clk(Q);
    check("t2_rd_cnt", 32'(rd_cnt), 32'd1);
    check("t2_busy", 32'(busy_o), 32'd0);

    // 3: wrong address 0x23 is not acknowledged
    i2c_start();
    write_byte(8'h46, ack); check("t3_addr_nack", 32'(ack), 32'd1);
    check("t3_busy", 32'(busy_o), 32'd0);
    check("t3_state", 32'(dbg_state), 32'(WAIT_STOP));
    i2c_stop(); wait_clk(Q);
    check("t3_wr_cnt", 32'(wr_cnt), 32'd1);

    // 4: pointer wrap on write (15 -> 0) and on read
    i2c_start();
    write_byte(8'h44, ack); check("t4_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h0F, ack); check("t4_ptr_ack", 32'(ack), 32'd0);
    exp_q.push_back({4'hF, 8'h11});
    write_byte(8'h11, ack); check("t4_d0_ack", 32'(ack), 32'd0);
    exp_q.push_back({4'h0, 8'h22});
    write_byte(8'h22, ack); check("t4_d1_ack", 32'(ack), 32'd0);
    i2c_stop(); wait_clk(Q);
    check("t4_wr_ptr_wrapped", 32'(wr_ptr_o), 32'h0);
    i2c_start();
    write_byte(8'h44, ack); check("t4_addr2_ack", 32'(ack), 32'd0);
    write_byte(8'h0F, ack); check("t4_ptr2_ack", 32'(ack), 32'd0);
    i2c_start();
    write_byte(8'h45, ack); check("t4_raddr_ack", 32'(ack), 32'd0);
    read_byte(rd, 1'b0);    check("t4_read0", 32'(rd), 32'h11);
    read_byte(rd, 1'b1);    check("t4_read1", 32'(rd), 32'h22);
    i2c_stop(); wait_clk(Q);
    check("t4_rd_cnt", 32'(rd_cnt), 32'd3);

    // 5: STOP after four data bits discards the byte
    i2c_start();
    write_byte(8'h44, ack); check("t5_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h05, ack); check("t5_ptr_ack", 32'(ack), 32'd0);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    i2c_stop(); wait_clk(Q);
    check("t5_state_idle", 32'(dbg_state), 32'(IDLE));
    check("t5_wr_cnt", 32'(wr_cnt), 32'd3);
    i2c_start();
    write_byte(8'h44, ack); check("t5_next_ack", 32'(ack), 32'd0);
    write_byte(8'h05, ack); check("t5_ptr2_ack", 32'(ack), 32'd0);
    i2c_start();
    write_byte(8'h45, ack); check("t5_raddr_ack", 32'(ack), 32'd0);
    read_byte(rd, 1'b1);    check("t5_mem_unchanged", 32'(rd), 32'h00);
    i2c_stop(); wait_clk(Q);

    // 6: reset while driving the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(addr_w[i]);
    check("t6_ack_driven", 32'(sda_o), 32'd0);
    check("t6_busy_before", 32'(busy_o), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_sda_released", 32'(sda_o), 32'd1);
    check("t6_busy_cleared", 32'(busy_o), 32'd0);
    wait_clk(1);
    rst = 1'b0;
    wait_clk(2);
    i2c_stop(); wait_clk(Q);
    i2c_start();
    write_byte(8'h44, ack); check("t6_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h03, ack); check("t6_ptr_ack", 32'(ack), 32'd0);
    i2c_start();
    write_byte(8'h45, ack); check("t6_raddr_ack", 32'(ack), 32'd0);
    read_byte(rd, 1'b1);    check("t6_mem_cleared", 32'(rd), 32'h00);
    i2c_stop(); wait_clk(Q);
    check("t6_rd_cnt", 32'(rd_cnt), 32'd5);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
